// File: rtl/button_menu.sv
// rtl/button_menu.sv - vertical stack of selectable menu buttons with press flash and confirm pulse
module button_menu #(
    parameter int          NUM_BUTTONS      = 4,
    parameter int          X_POS            = 240,
    parameter int          Y_POS            = 240,
    parameter int          WIDTH            = 154,
    parameter int          HEIGHT           = 52,
    parameter int          GAP              = 16,
    parameter logic [11:0] DESELECTED_COLOR = 12'hF50,
    parameter logic [11:0] SELECTED_COLOR   = 12'hFF0,
    parameter logic [11:0] PRESSED_COLOR    = 12'h0F0,
    parameter int          FLASH_FRAMES     = 8,
    localparam int         SW               = $clog2(NUM_BUTTONS)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic          new_frame_in,
    input  logic          up_in,
    input  logic          down_in,
    input  logic          confirm_in,
    input  logic          enable_in,
    output logic [SW-1:0] selected_out,
    output logic          busy_out,
    output logic          confirm_valid_out,
    output logic [SW-1:0] confirm_index_out,
    output logic          in_sprite_out,
    output logic [11:0]   pixel_out
);

    typedef enum logic {IDLE, FLASH} state_t;

    localparam logic [31:0] X_LO  = 32'(X_POS);
    localparam logic [31:0] X_HI  = 32'(X_POS + WIDTH);
    localparam logic [31:0] PITCH = 32'(HEIGHT + GAP);

    state_t        state, state_nxt;
    logic [SW-1:0] sel_nxt;
    logic [SW-1:0] ci_nxt;
    logic          cv_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          hit;
    logic [11:0]   color;
    logic [31:0]   h_ext, v_ext, y_top;

    assign busy_out = (state == FLASH);

    always_comb begin
        state_nxt = state;
        sel_nxt   = selected_out;
        cnt_nxt   = cnt;
        cv_nxt    = 1'b0;
        ci_nxt    = confirm_index_out;
        case (state)
            IDLE: begin
                if (enable_in) begin
                    if (confirm_in) begin
                        state_nxt = FLASH;
                        cnt_nxt   = 8'd0;
                    end else if (up_in && !down_in) begin
                        sel_nxt = (selected_out == '0) ? SW'(NUM_BUTTONS - 1) : selected_out - 1'b1;
                    end else if (down_in && !up_in) begin
                        sel_nxt = (selected_out == SW'(NUM_BUTTONS - 1)) ? '0 : selected_out + 1'b1;
                    end
                end
            end
            FLASH: begin
                // Only frame pulses matter here; every user input is dropped.
                if (new_frame_in) begin
                    if (cnt == 8'(FLASH_FRAMES - 1)) begin
                        state_nxt = IDLE;
                        cv_nxt    = 1'b1;
                        ci_nxt    = selected_out;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit   = 1'b0;
        color = 12'h000;
        h_ext = {21'd0, hcount_in};
        v_ext = {22'd0, vcount_in};
        y_top = 32'd0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            y_top = 32'(Y_POS) + 32'(i) * PITCH;
            if (h_ext >= X_LO && h_ext < X_HI && v_ext >= y_top && v_ext < y_top + 32'(HEIGHT)) begin
                hit = 1'b1;
                if (SW'(i) == selected_out)
                    color = (state == FLASH) ? PRESSED_COLOR : SELECTED_COLOR;
                else
                    color = DESELECTED_COLOR;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            selected_out      <= '0;
            cnt               <= 8'd0;
            confirm_valid_out <= 1'b0;
            confirm_index_out <= '0;
            in_sprite_out     <= 1'b0;
            pixel_out         <= 12'h000;
        end else begin
            state             <= state_nxt;
            selected_out      <= sel_nxt;
            cnt               <= cnt_nxt;
            confirm_valid_out <= cv_nxt;
            confirm_index_out <= ci_nxt;
            in_sprite_out     <= hit;
            pixel_out         <= color;
        end
    end

endmodule

// File: tb/tb_button_menu.sv
// tb/tb_button_menu.sv - self-checking bench for button_menu
module tb_button_menu;

    localparam int NB = 4;
    localparam int FF = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        new_frame = 0, up = 0, down = 0, confirm = 0, enable = 1;
    logic [1:0]  selected, confirm_index;
    logic        busy, confirm_valid, in_sprite;
    logic [11:0] pixel;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of the menu behaviour
    int          m_sel, m_frames, m_ci;
    bit          m_busy, m_cv, m_in;
    logic [11:0] m_pix;

    button_menu #(.NUM_BUTTONS(NB), .FLASH_FRAMES(FF)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .up_in(up), .down_in(down), .confirm_in(confirm),
        .enable_in(enable), .selected_out(selected), .busy_out(busy),
        .confirm_valid_out(confirm_valid), .confirm_index_out(confirm_index),
        .in_sprite_out(in_sprite), .pixel_out(pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] model_pixel(input int h, input int v, input int sel, input bit flashing);
        for (int i = 0; i < NB; i++) begin
            int top = 240 + i * (52 + 16);
            if (h >= 240 && h < 240 + 154 && v >= top && v < top + 52) begin
                if (i != sel)  return {1'b1, 12'hF50};
                if (flashing)  return {1'b1, 12'h0F0};
                return {1'b1, 12'hFF0};
            end
        end
        return 13'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel = 0; m_busy = 0; m_frames = 0; m_cv = 0; m_ci = 0; m_in = 0; m_pix = 0;
        end else begin
            {m_in, m_pix} = model_pixel(int'(hcount), int'(vcount), m_sel, m_busy);
            m_cv = 0;
            if (!m_busy) begin
                if (enable) begin
                    if (confirm) begin
                        m_busy = 1; m_frames = 0;
                    end else if (up && !down) m_sel = (m_sel + NB - 1) % NB;
                    else if (down && !up)     m_sel = (m_sel + 1) % NB;
                end
            end else if (new_frame) begin
                m_frames++;
                if (m_frames == FF) begin
                    m_busy = 0; m_cv = 1; m_ci = m_sel;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("selected",      selected,      m_sel);
        chk("busy",          busy,          m_busy);
        chk("confirm_valid", confirm_valid, m_cv);
        chk("confirm_index", confirm_index, m_ci);
        chk("in_sprite",     in_sprite,     m_in);
        chk("pixel",         pixel,         m_pix);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 0;
        tick(); tick(); tick();
        chk("rst selected", selected, 0);
        chk("rst pixel", pixel, 12'h000);
        hcount = 240; vcount = 240;
        rst_n = 1;
        tick(); chk("b0 selected px", pixel, 12'hFF0);
        vcount = 308;
        tick(); chk("b1 deselected px", pixel, 12'hF50);
        hcount = 394; vcount = 240;
        tick(); chk("right edge px", pixel, 12'h000); chk("right edge in", in_sprite, 0);
        hcount = 393; vcount = 291;
        tick(); chk("b0 corner px", pixel, 12'hFF0);
        hcount = 240; vcount = 292;
        tick(); chk("gap px", pixel, 12'h000);

        up = 1;   tick(); up = 0;   chk("wrap up", selected, 3);
        down = 1; tick(); down = 0; chk("wrap down", selected, 0);
        down = 1; tick(); down = 0; chk("down", selected, 1);
        up = 1; down = 1; tick(); up = 0; down = 0; chk("up+down", selected, 1);
        down = 1; tick(); down = 0; chk("down to 2", selected, 2);

        // Confirm with a coincident frame pulse: that pulse must not count.
        hcount = 240; vcount = 376;
        confirm = 1; new_frame = 1; tick(); confirm = 0; new_frame = 0;
        chk("busy after confirm", busy, 1);
        chk("px at confirm edge", pixel, 12'hFF0);
        tick(); chk("pressed px", pixel, 12'h0F0);
        up = 1;      tick(); up = 0;
        down = 1;    tick(); down = 0;
        confirm = 1; tick(); confirm = 0;
        chk("flash sel frozen", selected, 2);
        chk("flash still busy", busy, 1);
        new_frame = 1; tick(); new_frame = 0; tick();
        new_frame = 1; tick(); new_frame = 0;
        chk("busy after 2 frames", busy, 1);
        chk("no early pulse", confirm_valid, 0);
        new_frame = 1; confirm = 1; tick(); new_frame = 0; confirm = 0;
        chk("confirm pulse", confirm_valid, 1);
        chk("confirm index", confirm_index, 2);
        chk("busy cleared", busy, 0);
        tick();
        chk("pulse one cycle", confirm_valid, 0);
        chk("end confirm ignored", busy, 0);
        chk("index held", confirm_index, 2);
        chk("post flash px", pixel, 12'hFF0);

        enable = 0;
        up = 1;      tick(); up = 0;
        confirm = 1; tick(); confirm = 0;
        chk("disabled sel", selected, 2);
        chk("disabled busy", busy, 0);
        chk("disabled px", pixel, 12'hFF0);
        enable = 1;

        confirm = 1;   tick(); confirm = 0;
        new_frame = 1; tick(); new_frame = 0;
        chk("mid flash busy", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("async rst sel", selected, 0);
        chk("async rst busy", busy, 0);
        chk("async rst px", pixel, 12'h000);
        chk("async rst in", in_sprite, 0);
        chk("async rst cv", confirm_valid, 0);
        new_frame = 1; tick(); tick(); new_frame = 0;
        chk("no pulse in reset", confirm_valid, 0);
        rst_n = 1;
        tick(); chk("resume px", pixel, 12'hF50);
        down = 1; tick(); down = 0; chk("resume down", selected, 1);
        for (int i = 0; i < 4; i++) begin
            new_frame = 1; tick(); new_frame = 0; tick();
        end
        chk("no late pulse", confirm_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_menu.md
Name: button_menu

Overview:
- Vertical stack of NUM_BUTTONS rectangular menu buttons drawn into the 1024x768 pixel pipeline.
- Owns the selection index, which up_in/down_in move with wrap-around.
- On confirm_in, flashes the chosen button for a programmable number of frames, then reports the choice with a one-cycle pulse.
- Sits between the input-event logic and the video mixer; its pixel output is OR-mixed with the other sprites.

Parameters:
NUM_BUTTONS, 4, number of buttons (2..8)
X_POS, 240, left edge of every button, in pixels
Y_POS, 240, top edge of button 0, in lines
WIDTH, 154, button width, in pixels
HEIGHT, 52, button height, in lines
GAP, 16, blank lines between consecutive buttons
DESELECTED_COLOR, 12'hF50, fill colour of unselected buttons
SELECTED_COLOR, 12'hFF0, fill colour of the selected button
PRESSED_COLOR, 12'h0F0, fill colour of the selected button while flashing
FLASH_FRAMES, 8, frames the press flash lasts (1..255)

Ports:
clk_in  input  1  system clock (pixel clock)
rst_n_in  input  1  asynchronous active-low reset
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel line
new_frame_in  input  1  single-cycle pulse, once per frame
up_in  input  1  single-cycle pulse: move selection up (index-1)
down_in  input  1  single-cycle pulse: move selection down (index+1)
confirm_in  input  1  single-cycle pulse: press the selected button
enable_in  input  1  1 = accept navigation/confirm; 0 = drawing only
selected_out  output  $clog2(NUM_BUTTONS)  current selection index
busy_out  output  1  high while in FLASH
confirm_valid_out  output  1  one-cycle pulse at the end of a flash
confirm_index_out  output  $clog2(NUM_BUTTONS)  index pressed; valid with confirm_valid_out, held afterwards
in_sprite_out  output  1  registered: current pixel is inside any button
pixel_out  output  12  registered pixel colour; 0 outside buttons

Behaviour:
- Reset (async assert, sync release): state IDLE; selected_out=0; busy_out=0; confirm_valid_out=0; confirm_index_out=0; in_sprite_out=0; pixel_out=0; flash counter=0.
- Reset mid-flash aborts the flash immediately. No confirm pulse is issued.
- Button i occupies X_POS <= hcount_in < X_POS+WIDTH and Yi <= vcount_in < Yi+HEIGHT, where Yi = Y_POS + i*(HEIGHT+GAP).
  - All compares are unsigned and at least 12 bits wide, so the sums cannot overflow.
  - Rows fully below line 767 are never drawn, with no error.
- Pixel path has exactly 1 cycle latency: pixel_out and in_sprite_out at cycle t+1 reflect the hcount/vcount presented at t and the state at t.
- Colour priority for a button hit: PRESSED_COLOR if the state is FLASH and i==selected; else SELECTED_COLOR if i==selected; else DESELECTED_COLOR.
- State machine:
  - IDLE: acts on events only when enable_in=1.
    - up_in alone: selected = (selected==0) ? NUM_BUTTONS-1 : selected-1.
    - down_in alone: selected = (selected==NUM_BUTTONS-1) ? 0 : selected+1.
    - up_in and down_in together: no change.
    - confirm_in: go to FLASH, flash counter=0, busy_out=1 next cycle.
    - confirm_in takes priority over a same-cycle up/down; the selection does not move.
  - FLASH: up_in, down_in, confirm_in and enable_in are all ignored.
    - The counter increments on each new_frame_in.
    - When new_frame_in arrives with counter==FLASH_FRAMES-1: next cycle confirm_valid_out=1 and confirm_index_out=selected, busy_out=0, state IDLE.
  - confirm_valid_out is high for exactly one cycle.
  - A confirm_in in the same cycle the flash ends is ignored.
- Flash duration: FLASH_FRAMES new_frame_in pulses, counted from the first pulse strictly after the confirm cycle.
- selected_out is updated one cycle after the event. It is a register, not a combinational output.
- enable_in=0 never affects drawing.

Test Plan:
- Reset with NUM_BUTTONS=4 -> selected_out=0, pixel_out=0; after release, pixel at (240,240) gives pixel_out=12'hFF0 one cycle later; pixel at (240,308) (button 1) gives 12'hF50; pixel at (394,240) gives 0.
- Press up_in once from index 0 -> selected_out=3. Then press down_in twice -> 0, then 1. Pulse up_in and down_in together -> index unchanged.
- Press confirm_in at index 2 with FLASH_FRAMES=3 -> busy_out=1 next cycle; button 2 draws 12'h0F0. After the 3rd new_frame_in: one-cycle confirm_valid_out with confirm_index_out=2; busy_out=0; button 2 draws 12'hFF0.
- During FLASH, pulse up_in/down_in/confirm_in -> selected_out unchanged, no extra confirm pulse, flash length unchanged.
- Hold enable_in=0 and pulse up_in/confirm_in -> no state change; drawing unchanged.
- Assert rst_n_in low mid-flash -> outputs are immediately at reset values; no confirm_valid_out ever fires; normal operation resumes after release.
